// File: rtl/glyph_sprite.sv
// Bouncing glyph sprite overlay: moves once per frame, hit-tests each pixel, addresses the glyph ROM.
// Two-cycle latency from pixel coordinates to color; one pixel per cycle, never stalls.
module glyph_sprite #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int SCALE_LOG2 = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       frame_tick,
    output logic       sym,
    output logic [4:0] xaddr,
    output logic [4:0] yaddr,
    input  logic [2:0] rom_data,
    output logic [2:0] color,
    output logic       in_sprite
);
    localparam int         S    = 32 << SCALE_LOG2;
    localparam logic [9:0] SIZE = 10'(S);
    localparam logic [9:0] XMAX = 10'(H_ACTIVE - S);
    localparam logic [9:0] YMAX = 10'(V_ACTIVE - S);

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
        logic       bounce;
    } axis_t;

    // One frame step of a single axis; reversal at an edge still moves one pixel.
    function automatic axis_t step_axis(input logic [9:0] pos, input logic dir,
                                        input logic [9:0] lim);
        axis_t r;
        r.pos    = pos;
        r.dir    = dir;
        r.bounce = 1'b0;
        if (dir && pos >= lim) begin
            r.pos    = lim - 10'd1;
            r.dir    = 1'b0;
            r.bounce = 1'b1;
        end else if (!dir && pos == 10'd0) begin
            r.pos    = 10'd1;
            r.dir    = 1'b1;
            r.bounce = 1'b1;
        end else begin
            r.pos = dir ? pos + 10'd1 : pos - 10'd1;
        end
        return r;
    endfunction

    logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic       cur_sym_q, cur_sym_d;
    logic       sym_q, sym_d;
    logic [4:0] xaddr_q, xaddr_d, yaddr_q, yaddr_d;
    logic       hit1_q, hit1_d;
    logic [2:0] color_q, color_d;
    logic       in_sprite_q, in_sprite_d;

    logic [9:0] dx, dy;
    logic       hit;
    axis_t      ax, ay;

    always_comb begin
        // Wrapping subtraction makes pixels left of / above the sprite huge, so they miss.
        dx  = hpos - pos_x_q;
        dy  = vpos - pos_y_q;
        hit = (dx < SIZE) && (dy < SIZE);
        ax  = step_axis(pos_x_q, dir_x_q, XMAX);
        ay  = step_axis(pos_y_q, dir_y_q, YMAX);

        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        cur_sym_d = cur_sym_q;
        if (frame_tick) begin
            pos_x_d   = ax.pos;
            pos_y_d   = ay.pos;
            dir_x_d   = ax.dir;
            dir_y_d   = ay.dir;
            cur_sym_d = cur_sym_q ^ (ax.bounce | ay.bounce);
        end

        sym_d       = cur_sym_q;
        xaddr_d     = 5'(dx >> SCALE_LOG2);
        yaddr_d     = 5'(dy >> SCALE_LOG2);
        hit1_d      = hit & display_on;
        color_d     = hit1_q ? rom_data : 3'd0;
        in_sprite_d = hit1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_q     <= 10'd64;
            pos_y_q     <= 10'd48;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            cur_sym_q   <= 1'b0;
            sym_q       <= 1'b0;
            xaddr_q     <= 5'd0;
            yaddr_q     <= 5'd0;
            hit1_q      <= 1'b0;
            color_q     <= 3'd0;
            in_sprite_q <= 1'b0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            cur_sym_q   <= cur_sym_d;
            sym_q       <= sym_d;
            xaddr_q     <= xaddr_d;
            yaddr_q     <= yaddr_d;
            hit1_q      <= hit1_d;
            color_q     <= color_d;
            in_sprite_q <= in_sprite_d;
        end
    end

    assign sym       = sym_q;
    assign xaddr     = xaddr_q;
    assign yaddr     = yaddr_q;
    assign color     = color_q;
    assign in_sprite = in_sprite_q;
endmodule

// File: tb/tb_glyph_sprite.sv
// Randomized bench for glyph_sprite: a driver pushes expected responses, a monitor pops and compares.
module tb_glyph_sprite;
    localparam int SZ = 64;
    localparam int XM = 640 - SZ;
    localparam int YM = 480 - SZ;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hpos = '0, vpos = '0;
    logic       display_on = 1'b0, frame_tick = 1'b0;
    logic       sym;
    logic [4:0] xaddr, yaddr;
    logic [2:0] rom_data, color;
    logic       in_sprite;

    glyph_sprite #(.H_ACTIVE(640), .V_ACTIVE(480), .SCALE_LOG2(1)) dut (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .frame_tick(frame_tick),
        .sym(sym), .xaddr(xaddr), .yaddr(yaddr), .rom_data(rom_data),
        .color(color), .in_sprite(in_sprite)
    );

    always #5 clk = ~clk;

    // Character ROM stand-in; glyph 0 texel (0,0) reads 5.
    function automatic logic [2:0] rom(input logic s, input logic [4:0] y, input logic [4:0] x);
        return 3'(int'(x) + 2 * int'(y) + 3 * int'(s) + 5);
    endfunction
    assign rom_data = rom(sym, yaddr, xaddr);

    typedef struct { int due; logic s; logic [4:0] x; logic [4:0] y; } e1_t;
    typedef struct { int due; logic [2:0] c; logic hit; } e2_t;
    e1_t q1[$];
    e2_t q2[$];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference sprite state
    int mx = 64, my = 48;
    bit mdx = 1'b1, mdy = 1'b1, msym = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_tick();
        bit bx = 1'b0, by = 1'b0;
        if (mdx && mx == XM)      begin mdx = 1'b0; mx = mx - 1; bx = 1'b1; end
        else if (!mdx && mx == 0) begin mdx = 1'b1; mx = 1;      bx = 1'b1; end
        else                      mx = mdx ? mx + 1 : mx - 1;
        if (mdy && my == YM)      begin mdy = 1'b0; my = my - 1; by = 1'b1; end
        else if (!mdy && my == 0) begin mdy = 1'b1; my = 1;      by = 1'b1; end
        else                      my = mdy ? my + 1 : my - 1;
        if (bx || by) msym = ~msym;
    endtask

    function automatic int near(input int base);
        return (base + int'($urandom_range(0, 80)) - 8) & 1023;
    endfunction

    task automatic drive(input int h, input int v, input bit de, input bit ft);
        int dx, dy;
        bit hit;
        logic [4:0] ex, ey;
        @(negedge clk);
        check("pos_x", 32'(dut.pos_x_q), mx);
        check("pos_y", 32'(dut.pos_y_q), my);
        check("pos_x_range", 32'(dut.pos_x_q <= 10'(XM)), 1);
        check("pos_y_range", 32'(dut.pos_y_q <= 10'(YM)), 1);
        hpos = 10'(h);
        vpos = 10'(v);
        display_on = de;
        frame_tick = ft;
        dx  = (h - mx) & 1023;
        dy  = (v - my) & 1023;
        hit = (dx < SZ) && (dy < SZ) && de;
        ex  = 5'(dx / 2);
        ey  = 5'(dy / 2);
        q1.push_back('{due: cyc + 1, s: msym, x: ex, y: ey});
        q2.push_back('{due: cyc + 2, c: hit ? rom(msym, ey, ex) : 3'd0, hit: hit});
        if (ft) model_tick();
    endtask

    task automatic do_reset(input bit busy);
        @(negedge clk);
        #2;
        if (busy) check("in_sprite_pre_reset", 32'(in_sprite), 1);
        frame_tick = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_color", 32'(color), 0);
        check("rst_in_sprite", 32'(in_sprite), 0);
        check("rst_sym", 32'(sym), 0);
        check("rst_xaddr", 32'(xaddr), 0);
        check("rst_yaddr", 32'(yaddr), 0);
        check("rst_pos_x", 32'(dut.pos_x_q), 64);
        check("rst_pos_y", 32'(dut.pos_y_q), 48);
        q1.delete();
        q2.delete();
        mx = 64; my = 48; mdx = 1'b1; mdy = 1'b1; msym = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Place the sprite in the bottom-right corner heading outward on both axes.
    task automatic corner();
        @(negedge clk);
        frame_tick = 1'b0;
        display_on = 1'b0;
        q1.delete();
        q2.delete();
        force dut.pos_x_q = 10'd576;
        force dut.pos_y_q = 10'd416;
        force dut.dir_x_q = 1'b1;
        force dut.dir_y_q = 1'b1;
        @(negedge clk);
        release dut.pos_x_q;
        release dut.pos_y_q;
        release dut.dir_x_q;
        release dut.dir_y_q;
        mx = 576; my = 416; mdx = 1'b1; mdy = 1'b1;
    endtask

    e1_t m1;
    e2_t m2;
    always @(negedge clk) begin
        if (rst_n) begin
            while (q1.size() > 0 && q1[0].due <= cyc) begin
                m1 = q1.pop_front();
                check("s1_sym", 32'(sym), 32'(m1.s));
                check("s1_xaddr", 32'(xaddr), 32'(m1.x));
                check("s1_yaddr", 32'(yaddr), 32'(m1.y));
            end
            while (q2.size() > 0 && q2[0].due <= cyc) begin
                m2 = q2.pop_front();
                check("s2_color", 32'(color), 32'(m2.c));
                check("s2_in_sprite", 32'(in_sprite), 32'(m2.hit));
            end
        end
    end

    initial begin
        do_reset(1'b0);

        // Corners of the sprite, just outside it, wrap case and blanking
        drive(64, 48, 1, 0);
        drive(127, 111, 1, 0);
        drive(128, 111, 1, 0);
        drive(10, 10, 1, 0);
        drive(64, 48, 0, 0);
        drive(63, 48, 1, 0);
        drive(64, 47, 1, 0);
        drive(127, 112, 1, 0);
        drive(100, 80, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0)
                drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                      $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
            else
                drive(near(mx), near(my), $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
        end

        // Right-edge bounce from reset
        do_reset(1'b0);
        for (int i = 0; i < 512; i++) drive(near(mx), near(my), 1, 1);
        drive(near(mx), near(my), 1, 0);
        check("pos_x_peak", 32'(dut.pos_x_q), 576);
        drive(mx, my, 1, 1);
        drive(mx, my, 1, 0);
        check("pos_x_after_bounce", 32'(dut.pos_x_q), 575);
        for (int i = 0; i < 1200; i++) drive(near(mx), near(my), 1, 1);

        corner();
        drive(mx, my, 1, 1);
        drive(mx, my, 1, 0);
        check("corner_pos_x", 32'(dut.pos_x_q), 575);
        check("corner_pos_y", 32'(dut.pos_y_q), 415);
        check("corner_dir_x", 32'(dut.dir_x_q), 0);
        check("corner_dir_y", 32'(dut.dir_y_q), 0);
        for (int i = 0; i < 6; i++) drive(near(mx), near(my), 1, 1);

        // Reset while the sprite is being drawn
        drive(mx, my, 1, 0);
        drive(mx + 1, my, 1, 0);
        drive(mx + 2, my, 1, 0);
        do_reset(1'b1);
        drive(64, 48, 1, 0);
        drive(90, 60, 1, 0);
        drive(200, 60, 1, 0);

        @(negedge clk);
        display_on = 1'b0;
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("drain_q1", q1.size(), 0);
        check("drain_q2", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/glyph_sprite.md
GLYPH_SPRITE -- requirements
Module: glyph_sprite

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-003 Parameter SCALE_LOG2, 1, sprite magnification as a power of two (1 = each glyph texel is 2x2 screen pixels).
REQ-004 Port clk  in  1  pixel clock; all state on the rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port hpos  in  10  current horizontal pixel index.
REQ-007 Port vpos  in  10  current vertical line index.
REQ-008 Port display_on  in  1  high inside the active video area.
REQ-009 Port frame_tick  in  1  single-cycle pulse, once per frame, during vertical blank.
REQ-010 Port sym  out  1  glyph select to the character ROM.
REQ-011 Port xaddr  out  5  glyph column to the character ROM.
REQ-012 Port yaddr  out  5  glyph row to the character ROM.
REQ-013 Port rom_data  in  3  combinational texel from the character ROM for the current {sym,yaddr,xaddr}.
REQ-014 Port color  out  3  palette index for the pixel 2 cycles earlier; 0 means background.
REQ-015 Port in_sprite  out  1  high when color comes from the sprite.

Function
REQ-016 The block SHALL hold the sprite's top-left position pos_x[9:0] and pos_y[9:0], direction bits dir_x and dir_y (1 = increasing), and cur_sym.
REQ-017 Sprite size SHALL be S = 32 << SCALE_LOG2 pixels square; limits XMAX = H_ACTIVE - S and YMAX = V_ACTIVE - S.
REQ-018 On frame_tick, each axis SHALL be updated independently: if dir is 1 and pos == MAX, then dir <= 0 and pos <= pos-1; if dir is 0 and pos == 0, then dir <= 1 and pos <= 1; otherwise pos steps by 1 in the dir direction.
REQ-019 cur_sym SHALL toggle exactly once on a frame_tick where either axis or both axes bounce; a corner hit toggles it once, not twice.
REQ-020 Position, direction and cur_sym SHALL not change on cycles without frame_tick.
REQ-021 Hit SHALL be (hpos - pos_x) < S and (vpos - pos_y) < S, using 10-bit unsigned subtraction, so coordinates left of or above the sprite wrap and miss.
REQ-022 Stage 1 (1 cycle): register xaddr = (hpos-pos_x)>>SCALE_LOG2 [4:0], yaddr = (vpos-pos_y)>>SCALE_LOG2 [4:0], sym = cur_sym, and hit1 = hit AND display_on.
REQ-023 Stage 2 (1 cycle): register color = hit1 ? rom_data : 0 and in_sprite = hit1.
REQ-024 Total latency from hpos/vpos/display_on to color/in_sprite SHALL be exactly 2 cycles, with throughput of one pixel per cycle and no stalls.
REQ-025 A frame_tick position update SHALL affect the hit test from the next cycle on; the pipeline is never flushed.
REQ-026 While hit1 is 0, xaddr and yaddr SHALL still register their computed values, with no forced zero.
REQ-027 Position SHALL not leave the range [0,MAX] on any axis under any frame_tick sequence.

Reset
REQ-028 Asserting rst_n low SHALL immediately set pos_x=64, pos_y=48, dir_x=1, dir_y=1, cur_sym=0, sym=0, xaddr=0, yaddr=0, hit1=0, color=0 and in_sprite=0.
REQ-029 Reset mid-frame SHALL discard in-flight pipeline data; the first valid color SHALL appear 2 cycles after the first post-reset pixel input.

Verification
REQ-030 Reset, then hpos=64, vpos=48, display_on=1, rom_data=5 -> after 2 cycles color=5, in_sprite=1; with xaddr=0, yaddr=0, sym=0 after 1 cycle.
REQ-031 Reset, then hpos=127, vpos=111 -> xaddr=31, yaddr=31; hpos=128 -> in_sprite=0 and color=0 two cycles later.
REQ-032 hpos=10, vpos=10 (above/left of the sprite, wrap case) with rom_data=7 -> color=0 and in_sprite=0; the same happens for any hit with display_on=0.
REQ-033 Issue 512 frame_ticks from reset -> pos_x reaches 576, bounces and reads 575 on the next tick; cur_sym toggles at the bounce; pos_x and pos_y stay within [0,576] and [0,416] throughout.
REQ-034 Preload a corner: pos_x=576, pos_y=416, both dirs 1, then one frame_tick -> pos_x=575, pos_y=415, both dirs 0, and cur_sym toggles once.
REQ-035 Assert rst_n low for 1 cycle mid-stream while in_sprite=1 -> color and in_sprite go to 0 immediately, and the position returns to (64,48).
